// File: rtl/spi_slave_regfile_pkg.sv
// Shared constants, counter widths and FSM state encoding for the SPI slave register file.
package spi_regfile_pkg;

    localparam int WORD_W        = 16;
    localparam int WORDS_PER_GRP = 4;
    localparam int NUM_GRP       = 4;
    localparam int READ_GRP      = 3;
    localparam int SYNC_STAGES   = 2;

    localparam int NUM_WORDS  = NUM_GRP * WORDS_PER_GRP;
    localparam int BIT_CNT_W  = $clog2(WORD_W);
    localparam int WORD_CNT_W = $clog2(WORDS_PER_GRP);
    localparam int GRP_CNT_W  = $clog2(NUM_GRP);
    localparam int ADDR_W     = GRP_CNT_W + WORD_CNT_W;
    localparam int RD_W       = WORD_W * WORDS_PER_GRP;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FULL,
        ARMED,
        READ
    } state_t;

endpackage

// File: rtl/spi_slave_regfile_if.sv
// SPI pins plus the register-file read port, bundled for the slave and its driver.
interface spi_slave_regfile_if;
    import spi_regfile_pkg::*;

    logic              spi_clk;
    logic              spi_en;
    logic              spi_in;
    logic              spi_out;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              load_done;
    logic              frame_err;

    modport master (
        output spi_clk, spi_en, spi_in, rd_addr,
        input  spi_out, rd_data, load_done, frame_err
    );

    modport slave (
        input  spi_clk, spi_en, spi_in, rd_addr,
        output spi_out, rd_data, load_done, frame_err
    );

endinterface

// File: rtl/spi_slave_regfile_pin_sync.sv
// Synchronises the three SPI pins onto sys_clk and derives one-cycle edge strobes.
module spi_pin_sync
    import spi_regfile_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_pin,
    input  logic en_pin,
    input  logic in_pin,
    output logic in_s,
    output logic rise,
    output logic fall,
    output logic en_rise,
    output logic en_fall
);

    logic [STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [STAGES-1:0] en_sync_q, en_sync_d;
    logic [STAGES-1:0] in_sync_q, in_sync_d;
    logic              clk_prev_q, clk_prev_d;
    logic              en_prev_q, en_prev_d;
    logic              clk_s, en_s;

    assign clk_s = clk_sync_q[STAGES-1];
    assign en_s  = en_sync_q[STAGES-1];
    assign in_s  = in_sync_q[STAGES-1];

    // Shift each pin one stage deeper and remember last synchronised clk/en for edge detection.
    always_comb begin
        clk_sync_d = {clk_sync_q[STAGES-2:0], clk_pin};
        en_sync_d  = {en_sync_q[STAGES-2:0], en_pin};
        in_sync_d  = {in_sync_q[STAGES-2:0], in_pin};
        clk_prev_d = clk_s;
        en_prev_d  = en_s;
    end

    // Synchroniser flops reset to the idle bus levels so no spurious edge appears after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_q <= '0;
            en_sync_q  <= '1;
            in_sync_q  <= '0;
            clk_prev_q <= 1'b0;
            en_prev_q  <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            en_sync_q  <= en_sync_d;
            in_sync_q  <= in_sync_d;
            clk_prev_q <= clk_prev_d;
            en_prev_q  <= en_prev_d;
        end
    end

    assign rise    = clk_s & ~clk_prev_q;
    assign fall    = ~clk_s & clk_prev_q;
    assign en_rise = en_s & ~en_prev_q;
    assign en_fall = ~en_s & en_prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave: a write frame fills a 16-word register file, the following read frame returns the Corr group.
module spi_slave_regfile
    import spi_regfile_pkg::*;
(
    input  logic                sys_clk,
    input  logic                rst_n,
    spi_slave_regfile_if.slave  bus
);

    logic in_s, rise, fall, en_rise, en_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .clk_pin (bus.spi_clk),
        .en_pin  (bus.spi_en),
        .in_pin  (bus.spi_in),
        .in_s    (in_s),
        .rise    (rise),
        .fall    (fall),
        .en_rise (en_rise),
        .en_fall (en_fall)
    );

    state_t                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [GRP_CNT_W-1:0]  grp_cnt_q, grp_cnt_d;
    logic [WORD_W-2:0]     shreg_q, shreg_d;
    logic [RD_W-1:0]       rd_shreg_q, rd_shreg_d;
    logic                  spi_out_q, spi_out_d;
    logic                  load_done_q, load_done_d;
    logic                  frame_err_q, frame_err_d;
    logic                  ovr_q, ovr_d;
    logic [WORD_W-1:0]     regfile_q [NUM_WORDS];
    logic [WORD_W-1:0]     regfile_d [NUM_WORDS];

    logic [WORD_W-1:0]     wr_word;
    logic [ADDR_W-1:0]     wr_addr;
    logic [RD_W-1:0]       rd_load;
    logic                  last_bit, last_word, last_grp;

    // Group size is a power of two, so {group, word} is the flat regfile index.
    assign wr_word   = {shreg_q, in_s};
    assign wr_addr   = {grp_cnt_q, word_cnt_q};
    assign last_bit  = (bit_cnt_q == BIT_CNT_W'(WORD_W - 1));
    assign last_word = (word_cnt_q == WORD_CNT_W'(WORDS_PER_GRP - 1));
    assign last_grp  = (grp_cnt_q == GRP_CNT_W'(NUM_GRP - 1));

    // Assemble the read-back image with word 0 of the read group in the MSBs.
    always_comb begin
        rd_load = '0;
        for (int w = 0; w < WORDS_PER_GRP; w++) begin
            rd_load[RD_W-1-w*WORD_W -: WORD_W] = regfile_q[READ_GRP*WORDS_PER_GRP + w];
        end
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; en_rise always takes priority over a coincident clock edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_fall) state_d = WRITE;
            WRITE: begin
                if (en_rise)                                          state_d = IDLE;
                else if (rise && last_bit && last_word && last_grp)   state_d = FULL;
            end
            FULL:    if (en_rise) state_d = ARMED;
            ARMED:   if (en_fall) state_d = READ;
            READ:    if (en_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic: deserialise, write words, flag errors, shift the read image out.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        grp_cnt_d   = grp_cnt_q;
        shreg_d     = shreg_q;
        rd_shreg_d  = rd_shreg_q;
        spi_out_d   = 1'b0;
        load_done_d = 1'b0;
        frame_err_d = 1'b0;
        ovr_d       = ovr_q;
        regfile_d   = regfile_q;
        case (state_q)
            IDLE: begin
                if (en_fall) begin
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    grp_cnt_d  = '0;
                    shreg_d    = '0;
                    ovr_d      = 1'b0;
                end
            end
            WRITE: begin
                if (en_rise) begin
                    frame_err_d = 1'b1;
                end else if (rise) begin
                    shreg_d = wr_word[WORD_W-2:0];
                    if (last_bit) begin
                        regfile_d[wr_addr] = wr_word;
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (last_word) begin
                            grp_cnt_d = grp_cnt_q + 1'b1;
                            if (last_grp) load_done_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (!en_rise && rise && !ovr_q) begin
                    frame_err_d = 1'b1;
                    ovr_d       = 1'b1;
                end
            end
            ARMED: begin
                if (en_fall) begin
                    spi_out_d  = rd_load[RD_W-1];
                    rd_shreg_d = {rd_load[RD_W-2:0], 1'b0};
                end
            end
            READ: begin
                if (en_rise) begin
                    spi_out_d = 1'b0;
                end else if (fall) begin
                    spi_out_d  = rd_shreg_q[RD_W-1];
                    rd_shreg_d = {rd_shreg_q[RD_W-2:0], 1'b0};
                end else begin
                    spi_out_d = spi_out_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath flops and the register file.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            grp_cnt_q   <= '0;
            shreg_q     <= '0;
            rd_shreg_q  <= '0;
            spi_out_q   <= 1'b0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_q       <= 1'b0;
            regfile_q   <= '{default: '0};
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            grp_cnt_q   <= grp_cnt_d;
            shreg_q     <= shreg_d;
            rd_shreg_q  <= rd_shreg_d;
            spi_out_q   <= spi_out_d;
            load_done_q <= load_done_d;
            frame_err_q <= frame_err_d;
            ovr_q       <= ovr_d;
            regfile_q   <= regfile_d;
        end
    end

    assign bus.spi_out   = spi_out_q;
    assign bus.load_done = load_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rd_data   = regfile_q[bus.rd_addr];

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- Chip-side SPI slave that consumes the serial stream from the project SPI test generator: spi_in data, gated spi_clk_out, and the active-low spi_en frame strobe.
- Oversamples all SPI pins on sys_clk.
- A write frame deserialises 16-bit words into a 4-group x 4-word register file (groups A, B, C, Corr).
- The next frame is a read frame that shifts the Corr group back out on spi_out.

Parameters:
- WORD_W, 16, bits per word
- WORDS_PER_GRP, 4, words per address group
- NUM_GRP, 4, number of groups; the register file holds NUM_GRP*WORDS_PER_GRP words
- READ_GRP, 3, group index returned during a read frame
- SYNC_STAGES, 2, synchroniser depth on spi_clk, spi_en and spi_in

Ports:
- sys_clk  input  1  system clock
- rst_n  input  1  reset, synchronous and active-low
- spi_clk  input  1  SPI clock from the master; idles low
- spi_en  input  1  frame enable, active-low
- spi_in  input  1  serial data, MOSI
- spi_out  output  1  serial data, MISO
- rd_addr  input  4  register-file read address, {group, word}
- rd_data  output  WORD_W  combinational read of regfile[rd_addr]
- load_done  output  1  one-cycle pulse when a write frame completes
- frame_err  output  1  one-cycle pulse when a frame aborts or overruns

Behaviour:
- Reset: synchronous, active-low, sampled on the sys_clk rising edge. It clears the following:
  - all regfile words to 0, spi_out=0, load_done=0, frame_err=0
  - bit_cnt, word_cnt and grp_cnt to 0
  - state to IDLE and the synchroniser flops to idle values (spi_en=1, spi_clk=0)
  - Reset mid-frame aborts the frame; no error pulse is raised.
- Sampling:
  - Each SPI input passes through SYNC_STAGES flops.
  - rise/fall are one-cycle detects on the synchronised spi_clk.
  - en_fall/en_rise are one-cycle detects on the synchronised spi_en.
- SPI timing: the master holds each spi_clk phase for at least SYNC_STAGES+2 sys_clk cycles.
- State IDLE:
  - en_fall goes to WRITE.
  - Counters are cleared on entry.
- State WRITE:
  - On rise, shift the synchronised spi_in into shreg; the first bit received becomes the MSB.
  - bit_cnt counts 0..15.
  - When the 16th bit arrives, write the word to regfile[grp_cnt*4+word_cnt] in the same cycle, then advance word_cnt. On word_cnt wrap, advance grp_cnt.
  - After word 15 is written: load_done pulses the next cycle and the state moves to FULL.
  - en_rise before 256 bits: pulse frame_err, discard the partial word, return to IDLE. Words already written are kept.
- State FULL:
  - Further rise edges while spi_en is low are ignored.
  - The first such rise pulses frame_err once (overrun).
  - en_rise moves to ARMED.
- State ARMED:
  - en_fall moves to READ.
  - On entry to READ, the read shift register loads regfile words READ_GRP*4 .. READ_GRP*4+3, concatenated with word 0 as the MSBs. This gives 64 bits.
  - spi_out drives the MSB one sys_clk after en_fall is detected.
- State READ:
  - Each fall shifts left by one; spi_out updates 1 sys_clk after the fall detect.
  - After 64 bits have been shifted out, spi_out holds 0 for any extra clocks.
  - rise edges are ignored, and spi_in is ignored.
  - en_rise returns to IDLE with spi_out=0.
  - A new write frame requires returning to IDLE.
- Latency from pin edge to internal action: SYNC_STAGES+1 sys_clk cycles.
- Simultaneous events: if en_rise and a clock edge are detected in the same cycle, en_rise wins and the edge is dropped.
- spi_out outside READ: 0.
- Regfile write port: used only by WRITE.
- rd_data: always combinational; it reflects a write on the cycle after the write.

Decomposition:
- Package spi_regfile_pkg contains:
  - state enum {IDLE, WRITE, FULL, ARMED, READ}
  - constants WORD_W, WORDS_PER_GRP, NUM_GRP, READ_GRP
  - derived widths for the bit, word and group counters
- One sub-module, spi_pin_sync, performs the SYNC_STAGES synchronisation of the three pins and produces the rise/fall/en_rise/en_fall one-cycle strobes.
- Shift registers, counters and the FSM stay in the top level.

Test Plan:
- Full load: 256 bits, where groups A and B are 0xFFFF, C is 0x0003, and Corr is FFFF, 5554, 0000, 0000. Required: load_done pulses once; rd_addr 0..15 returns those words; frame_err stays 0.
- Readback: after the full load, toggle spi_en high then low and issue 68 clocks. Required: spi_out bits 0..63 equal 0xFFFF_5554_0000_0000 MSB-first, and bits 64..67 are 0.
- Abort: deassert spi_en after 20 bits. Required:
  - frame_err pulses once, and the state is back at IDLE.
  - regfile[0] holds the first 16 bits; regfile[1] is unchanged at 0.
- Overrun: write 260 bits in one frame. Required: one frame_err pulse after bit 257; regfile contents equal the first 256 bits.
- Reset mid-READ: assert rst_n low for 1 cycle after 10 read bits. Required:
  - spi_out=0 and the regfile is all-zero.
  - The next frame is treated as a write frame.
- Edge race: make en_rise coincide with the 16th rise of the first word. Required: the word is not written, and frame_err pulses.
